data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Synchronous single-port data SRAM responder serving the CPU's data-sram port. It accepts `data_sram_en/wen/addr/wdata` issued by the execute stage and returns `data_sram_rdata` one cycle later, when the memory stage consumes it as load data. After reset it runs a self-clear sequence so that every word reads zero before the first access is honoured. It also flags accesses that fall outside its mapped window.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-address width; depth = 2^ADDR_BITS words of 32 bits.
- `BASE_ADDR`, default 32'h0000_0000: window base. Only bits [31:ADDR_BITS+2] are compared.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_sram_en`  in  1  access request this cycle.
- `data_sram_wen`  in  4  byte write enables; bit i writes wdata[8i+7:8i]. 4'b0000 means read.
- `data_sram_addr`  in  32  byte address; bits [1:0] are ignored; word index = addr[ADDR_BITS+1:2].
- `data_sram_wdata`  in  32  store data.
- `data_sram_rdata`  out  32  registered read data.
- `data_sram_addr_err`  out  1  registered one-cycle flag for an out-of-window access.
- `sram_init_done`  out  1  high once the self-clear has completed.

## Operation
- State machine with two states, CLEAR and READY. Reset value is CLEAR; clear counter `clr_idx` resets to 0.
- CLEAR: each cycle writes 32'h0 to word `clr_idx`, then increments the counter.
  - When `clr_idx` = 2^ADDR_BITS−1 is written, the next state is READY. CLEAR therefore lasts exactly 2^ADDR_BITS cycles.
  - External requests are ignored: no write, `rdata` is loaded with 0, and `addr_err` stays 0.
- READY: `clr_idx` holds; the state stays READY until reset.
- A request (en=1) is in-window when addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2].
- In-window read (wen=0): `rdata` is loaded with mem[idx].
- In-window write (wen≠0):
  - Only enabled byte lanes of mem[idx] are updated; other lanes keep their value.
  - `rdata` is loaded with the pre-write word (read-first semantics).
- Out-of-window request:
  - No memory update.
  - `rdata` is loaded with 0.
  - `addr_err` is set to 1 for that single registered cycle.
- en=0: `rdata` holds its previous value; `addr_err` is cleared to 0.
- Reset values: `data_sram_rdata`=0, `data_sram_addr_err`=0, `sram_init_done`=0.
- Memory contents are not reset asynchronously; CLEAR provides the defined zero state.
- Asserting `resetn` low mid-CLEAR or mid-READY returns the block to CLEAR with `clr_idx`=0. The full clear reruns.

## Timing
- Read latency is 1 cycle. With en=1 sampled at edge N, `rdata` and `addr_err` are valid from just after edge N until edge N+1. This matches the memory stage consuming the load data in the cycle after execute.
- Write latency: the array is updated at edge N. A read of the same word at edge N+1 returns the new data.
- Back-to-back accesses are supported every cycle. There is no stall or ready output; the block always accepts in READY.
- `sram_init_done` rises at the edge that enters READY, which is edge 2^ADDR_BITS after reset release. A request sampled at that same edge is still treated as a CLEAR-state request. The first honoured request is at the next edge.
- `resetn` deassertion is sampled synchronously. The first CLEAR write happens at the first rising edge with `resetn`=1.

## Test plan
- Reset/clear (ADDR_BITS=4): release reset, then read all 16 words. Required: `sram_init_done`=0 for 16 edges, then 1; every read returns 32'h0 with `addr_err`=0.
- Byte-lane write: after init, write 32'hAABBCCDD with wen=4'hF to addr 0x8, then 32'h11223344 with wen=4'b0101. Required: the second write returns `rdata`=32'hAABBCCDD (read-first); a subsequent read of 0x8 returns 32'hAA22CC44.
- Back-to-back pipeline traffic: write 0x1 to addr 0x0 and 0x2 to 0x4, then read 0x0, 0x4, 0x0 on consecutive cycles. Required: `rdata` is 1, 2, 1 on the cycles directly after each read edge.
- Hold and out-of-window: read 0x4 (returns 2), then en=0 for 3 cycles, then read addr 0x0001_0000 with BASE_ADDR=0. Required: `rdata` holds 2 for the 3 idle cycles; the out-of-window read gives `rdata`=0 and `addr_err`=1 for exactly one cycle; memory is unchanged.
- Request during CLEAR: issue a write of 32'hDEADBEEF to 0x0 at cycle 3 after reset release. Required: ignored, `rdata`=0; after init, a read of 0x0 returns 0.
- Reset mid-operation: after writing 32'h5 to 0xC, pulse `resetn` low asynchronously between edges. Required: `rdata`, `addr_err` and `sram_init_done` go to 0 immediately; the clear reruns for 16 cycles; a read of 0xC afterwards returns 0.

Source files
------------

// File: rtl/data_sram_responder.sv
// Single-port 32-bit data SRAM responder for the CPU data-sram port.
// Self-clears every word after reset, then serves 1-cycle read-first accesses and flags out-of-window requests.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to word clr_idx each cycle, requests ignored
// ST_READY | serving requests until the next reset
module data_sram_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_addr_err,
  output logic        sram_init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] IDX_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_idx_q, clr_idx_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  addr_err_q, addr_err_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0]  req_idx;
  logic                  req_in_win;
  logic [31:0]           mem_rd;
  logic [3:0]            mem_be;
  logic [ADDR_BITS-1:0]  mem_widx;
  logic [31:0]           mem_wdata;
  logic                  unused_addr_lsb;

  assign req_idx         = data_sram_addr[ADDR_BITS+1:2];
  assign req_in_win      = (data_sram_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign mem_rd          = mem[req_idx];
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rdata_d    = rdata_q;
    addr_err_d = 1'b0;
    mem_be     = 4'b0000;
    mem_widx   = req_idx;
    mem_wdata  = data_sram_wdata;
    case (state_q)
      ST_CLEAR: begin
        mem_be    = 4'b1111;
        mem_widx  = clr_idx_q;
        mem_wdata = 32'h0;
        rdata_d   = 32'h0;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          clr_idx_d = clr_idx_q + IDX_ONE;
        end
      end
      ST_READY: begin
        if (data_sram_en) begin
          if (req_in_win) begin
            // read-first: rdata takes the word as it was before this write
            rdata_d = mem_rd;
            mem_be  = data_sram_wen;
          end else begin
            rdata_d    = 32'h0;
            addr_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      rdata_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  // array has no reset; the CLEAR pass defines its contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) begin
        mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_rdata    = rdata_q;
  assign data_sram_addr_err = addr_err_q;
  assign sram_init_done     = (state_q == ST_READY);

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder (ADDR_BITS=4, BASE_ADDR=0).
// A word-array reference model predicts rdata/addr_err/init_done for every cycle.
module tb_data_sram_responder;

  localparam int unsigned WORDS = 16;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_addr_err;
  logic        sram_init_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [WORDS];
  int          clr_edges;
  logic [31:0] exp_rdata;
  logic        exp_err;
  logic        exp_done;

  data_sram_responder #(
    .ADDR_BITS(4),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .data_sram_en       (data_sram_en),
    .data_sram_wen      (data_sram_wen),
    .data_sram_addr     (data_sram_addr),
    .data_sram_wdata    (data_sram_wdata),
    .data_sram_rdata    (data_sram_rdata),
    .data_sram_addr_err (data_sram_addr_err),
    .sram_init_done     (sram_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // model: memory reads as zero after a reset; the first 16 edges after release are clear cycles
  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    clr_edges = 0;
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    exp_done  = 1'b0;
  endtask

  // drive one request, advance one edge, sample 1 time unit later, update the model
  task automatic step(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int idx;
    logic [31:0] lane;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    if (clr_edges < WORDS) begin
      exp_rdata = 32'h0;
      exp_err   = 1'b0;
      clr_edges++;
    end else begin
      exp_err = 1'b0;
      if (en) begin
        if ((addr >> 6) == 0) begin
          idx = int'((addr >> 2) % WORDS);
          exp_rdata = model_mem[idx];
          for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
              lane = 32'hFF << (8 * b);
              model_mem[idx] = (model_mem[idx] & ~lane) | (wdata & lane);
            end
          end
        end else begin
          exp_rdata = 32'h0;
          exp_err   = 1'b1;
        end
      end
    end
    exp_done = (clr_edges >= WORDS);
    data_sram_en = 1'b0;
  endtask

  task automatic idle_until_ready();
    while (clr_edges < WORDS) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    data_sram_en = 1'b0;
    data_sram_wen = 4'h0;
    data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b0 || sram_init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h err=%b done=%b, required 0/0/0",
               data_sram_rdata, data_sram_addr_err, sram_init_done);
    end
    resetn = 1'b1;
    for (int k = 1; k <= WORDS; k++) begin
      step(1'b1, 4'h0, 32'(k * 4), 32'h0);
      checks++;
      if (sram_init_done !== (k == WORDS) || data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b0) begin
        errors++;
        $display("FAIL clear_edge_%0d: done=%b rdata=%h err=%b, required done=%b rdata=0 err=0",
                 k, sram_init_done, data_sram_rdata, data_sram_addr_err, (k == WORDS));
      end
    end
    for (int w = 0; w < WORDS; w++) begin
      step(1'b1, 4'h0, 32'(w * 4), 32'h0);
      checks++;
      if (data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b0 || sram_init_done !== 1'b1) begin
        errors++;
        $display("FAIL cleared_word_%0d: rdata=%h err=%b done=%b, required 0/0/1",
                 w, data_sram_rdata, data_sram_addr_err, sram_init_done);
      end
    end
  endtask

  task automatic test_byte_lane();
    step(1'b1, 4'hF, 32'h8, 32'hAABBCCDD);
    step(1'b1, 4'b0101, 32'h8, 32'h11223344);
    checks++;
    if (data_sram_rdata !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL read_first: rdata=%h, required aabbccdd", data_sram_rdata);
    end
    step(1'b1, 4'h0, 32'h8, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'hAA22CC44 || data_sram_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL byte_merge: rdata=%h, required aa22cc44", data_sram_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    logic [31:0] addrs [3];
    want[0] = 32'h1; want[1] = 32'h2; want[2] = 32'h1;
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h0;
    step(1'b1, 4'hF, 32'h0, 32'h1);
    step(1'b1, 4'hF, 32'h4, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h0, addrs[i], 32'h0);
      checks++;
      if (data_sram_rdata !== want[i] || data_sram_addr_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_read_%0d: rdata=%h err=%b, required %h err=0",
                 i, data_sram_rdata, data_sram_addr_err, want[i]);
      end
    end
  endtask

  task automatic test_hold_oob();
    step(1'b1, 4'h0, 32'h4, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h2) begin
      errors++;
      $display("FAIL hold_setup: rdata=%h, required 2", data_sram_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (data_sram_rdata !== 32'h2 || data_sram_addr_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_idle_%0d: rdata=%h err=%b, required 2 err=0",
                 i, data_sram_rdata, data_sram_addr_err);
      end
    end
    step(1'b1, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
    checks++;
    if (data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_access: rdata=%h err=%b, required 0 err=1", data_sram_rdata, data_sram_addr_err);
    end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_sram_addr_err !== 1'b0 || data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oob_one_cycle: err=%b rdata=%h, required err=0 rdata=0",
               data_sram_addr_err, data_sram_rdata);
    end
    step(1'b1, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h1) begin
      errors++;
      $display("FAIL oob_no_write: rdata=%h, required 1", data_sram_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  wen;
    logic        en;
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      addr = $urandom;
      if ($urandom_range(0, 7) != 0) addr = addr & 32'h0000_003F;
      else if ((addr >> 6) == 0) addr = addr | 32'h0000_1000;
      step(en, wen, addr, $urandom);
      checks++;
      if (data_sram_rdata !== exp_rdata || data_sram_addr_err !== exp_err || sram_init_done !== exp_done) begin
        errors++;
        $display("FAIL random_%0d: rdata=%h err=%b done=%b, required %h err=%b done=%b",
                 i, data_sram_rdata, data_sram_addr_err, sram_init_done, exp_rdata, exp_err, exp_done);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'hF, 32'hC, 32'h5);
    step(1'b1, 4'h0, 32'hC, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h5) begin
      errors++;
      $display("FAIL mid_setup: rdata=%h, required 5", data_sram_rdata);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b0 || sram_init_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: rdata=%h err=%b done=%b, required 0/0/0",
               data_sram_rdata, data_sram_addr_err, sram_init_done);
    end
    @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    for (int k = 1; k <= WORDS; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      checks++;
      if (sram_init_done !== (k == WORDS)) begin
        errors++;
        $display("FAIL reclear_edge_%0d: done=%b, required %b", k, sram_init_done, (k == WORDS));
      end
    end
    step(1'b1, 4'h0, 32'hC, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reclear_word: rdata=%h, required 0", data_sram_rdata);
    end
  endtask

  task automatic test_clear_request();
    #2 resetn = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'hF, 32'h0, 32'hDEADBEEF);
    checks++;
    if (data_sram_rdata !== 32'h0 || data_sram_addr_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_req_resp: rdata=%h err=%b, required 0 err=0", data_sram_rdata, data_sram_addr_err);
    end
    idle_until_ready();
    step(1'b1, 4'h0, 32'h0, 32'h0);
    checks++;
    if (data_sram_rdata !== 32'h0) begin
      errors++;
      $display("FAIL clear_req_ignored: rdata=%h, required 0", data_sram_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_byte_lane();
    test_back_to_back();
    test_hold_oob();
    test_random();
    test_reset_mid();
    test_clear_request();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
